// File: rtl/rojo_evt_latch.sv
// Multi-channel sticky event latch with optional input synchroniser,
// edge/level detection, per-channel missed-event counters and a
// lowest-index interrupt encoder.
//
// Per-channel FSM:
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no event outstanding, o_pend bit low
//   ST_PEND | event captured and not yet acknowledged, o_pend bit high
module rojo_evt_latch #(
  parameter int NCH   = 4,
  parameter int CNT_W = 4,
  parameter int SYNC  = 1,
  localparam int IDW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NCH-1:0]       i_evt,
  input  logic [NCH-1:0]       i_mode,
  input  logic [NCH-1:0]       i_mask,
  input  logic [NCH-1:0]       i_ack,
  input  logic [NCH-1:0]       i_clr_missed,
  output logic [NCH-1:0]       o_pend,
  output logic                 o_irq,
  output logic [IDW-1:0]       o_evt_id,
  output logic                 o_evt_valid,
  output logic [NCH*CNT_W-1:0] o_missed
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MISS_MAX = '1;

  logic [NCH-1:0] evt_s;
  logic [NCH-1:0] prev_q;
  logic [NCH-1:0] detect;
  logic [NCH-1:0] pend_en;
  logic [IDW-1:0] evt_id_d;

  // Optional two-flop synchroniser in front of the detectors.
  generate
    if (SYNC == 1) begin : g_sync
      logic [NCH-1:0] sync1_q;
      logic [NCH-1:0] sync2_q;

      // Two-stage resynchronisation of the raw event inputs.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= i_evt;
          sync2_q <= sync1_q;
        end
      end

      assign evt_s = sync2_q;
    end else begin : g_nosync
      assign evt_s = i_evt;
    end
  endgenerate

  // Previous sampled value for rising-edge detection; cleared by reset so a
  // level already high at release is seen as an edge on the first clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
    end else begin
      prev_q <= evt_s;
    end
  end

  // Detect term: edge in mode 0, raw level in mode 1.
  always_comb begin
    detect = '0;
    for (int k = 0; k < NCH; k++) begin
      detect[k] = i_mode[k] ? evt_s[k] : (evt_s[k] & ~prev_q[k]);
    end
  end

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] miss_q, miss_d;
      logic             inc;

      // A fresh edge arriving while still pending and not being acked is a
      // lost event; an ack in the same cycle hands the new event over instead.
      assign inc = (state_q == ST_PEND) && detect[k] && !i_ack[k] && !i_mode[k];

      // Channel state register.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          state_q <= ST_IDLE;
        end else begin
          state_q <= state_d;
        end
      end

      // Next-state: capture on detect, release on ack only when no new detect.
      always_comb begin
        state_d = state_q;
        case (state_q)
          ST_IDLE: begin
            if (detect[k]) begin
              state_d = ST_PEND;
            end
          end
          ST_PEND: begin
            if (i_ack[k] && !detect[k]) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      // Missed counter register.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          miss_q <= '0;
        end else begin
          miss_q <= miss_d;
        end
      end

      // Saturating increment; a clear coinciding with an increment keeps that one event.
      always_comb begin
        miss_d = miss_q;
        if (i_clr_missed[k]) begin
          miss_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (miss_q != MISS_MAX)) begin
          miss_d = miss_q + CNT_W'(1);
        end
      end

      assign o_pend[k]                    = (state_q == ST_PEND);
      assign o_missed[k*CNT_W +: CNT_W]   = miss_q;
    end
  endgenerate

  assign pend_en = o_pend & i_mask;

  // Lowest-index enabled pending channel; scanning downward lets the lowest win.
  always_comb begin
    evt_id_d = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend_en[k]) begin
        evt_id_d = IDW'(k);
      end
    end
  end

  assign o_irq       = |pend_en;
  assign o_evt_valid = o_irq;
  assign o_evt_id    = evt_id_d;

endmodule

// File: tb/tb_rojo_evt_latch.sv
// Directed bench for rojo_evt_latch at NCH=4, CNT_W=4, SYNC=1.
module tb_rojo_evt_latch;

  logic        clk;
  logic        rstn;
  logic [3:0]  i_evt;
  logic [3:0]  i_mode;
  logic [3:0]  i_mask;
  logic [3:0]  i_ack;
  logic [3:0]  i_clr_missed;
  logic [3:0]  o_pend;
  logic        o_irq;
  logic [1:0]  o_evt_id;
  logic        o_evt_valid;
  logic [15:0] o_missed;

  int n_chk;
  int n_fail;

  rojo_evt_latch #(.NCH(4), .CNT_W(4), .SYNC(1)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_evt        (i_evt),
    .i_mode       (i_mode),
    .i_mask       (i_mask),
    .i_ack        (i_ack),
    .i_clr_missed (i_clr_missed),
    .o_pend       (o_pend),
    .o_irq        (o_irq),
    .o_evt_id     (o_evt_id),
    .o_evt_valid  (o_evt_valid),
    .o_missed     (o_missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on the given channels; returns when the capture edge has passed.
  task automatic pulse_evt(input logic [3:0] ch);
    i_evt = ch;
    tick();
    i_evt = '0;
    tick();
    tick();
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rstn         = 1'b0;
    i_evt        = '0;
    i_mode       = '0;
    i_mask       = '0;
    i_ack        = '0;
    i_clr_missed = '0;

    #12;
    chk("rst_pend",   32'(o_pend), 32'h0);
    chk("rst_irq",    32'(o_irq), 32'h0);
    chk("rst_id",     32'(o_evt_id), 32'h0);
    chk("rst_valid",  32'(o_evt_valid), 32'h0);
    chk("rst_missed", 32'(o_missed), 32'h0);
    rstn = 1'b1;
    tick();

    // Edge capture with 3-cycle latency, then ack.
    i_mask = 4'b0010;
    i_evt  = 4'b0010;
    tick();
    i_evt = '0;
    tick();
    chk("lat_not_yet", 32'(o_pend), 32'h0);
    tick();
    chk("lat_pend",  32'(o_pend), 32'h2);
    chk("lat_irq",   32'(o_irq), 32'h1);
    chk("lat_id",    32'(o_evt_id), 32'h1);
    chk("lat_valid", 32'(o_evt_valid), 32'h1);
    i_ack = 4'b0010;
    tick();
    i_ack = '0;
    chk("ack_pend", 32'(o_pend), 32'h0);
    chk("ack_irq",  32'(o_irq), 32'h0);

    // Missed counter saturation and clear on ch0 (masked off: capture still happens).
    pulse_evt(4'b0001);
    chk("miss_first_pend", 32'(o_pend), 32'h1);
    chk("miss_first_cnt",  32'(o_missed), 32'h0);
    chk("masked_irq",      32'(o_irq), 32'h0);
    for (int i = 1; i <= 20; i++) begin
      pulse_evt(4'b0001);
      if (i == 3) chk("miss_cnt3", 32'(o_missed), 32'h3);
    end
    chk("miss_sat",  32'(o_missed), 32'hF);
    chk("miss_pend", 32'(o_pend), 32'h1);
    i_clr_missed = 4'b0001;
    tick();
    i_clr_missed = '0;
    chk("miss_clr", 32'(o_missed), 32'h0);

    // Clear coinciding with an increment leaves the count at 1.
    i_evt = 4'b0001;
    tick();
    i_evt = '0;
    tick();
    i_clr_missed = 4'b0001;
    tick();
    i_clr_missed = '0;
    chk("clr_inc", 32'(o_missed), 32'h1);
    i_ack = 4'b0001;
    tick();
    i_ack = '0;
    chk("ch0_acked", 32'(o_pend), 32'h0);

    // Ack coincident with new edge on ch2.
    pulse_evt(4'b0100);
    chk("ch2_pend", 32'(o_pend), 32'h4);
    i_evt = 4'b0100;
    tick();
    i_evt = '0;
    tick();
    i_ack = 4'b0100;
    tick();
    i_ack = '0;
    chk("ackdet_pend",   32'(o_pend), 32'h4);
    chk("ackdet_missed", 32'(o_missed), 32'h0001);
    i_ack = 4'b0100;
    tick();
    i_ack = '0;
    chk("ch2_acked", 32'(o_pend), 32'h0);
    i_ack = 4'b0100;
    tick();
    i_ack = '0;
    chk("idle_ack", 32'(o_pend), 32'h0);

    // Priority encoding and masking with ch0 and ch3 pending.
    pulse_evt(4'b1001);
    i_mask = 4'b1001;
    #1;
    chk("prio_pend", 32'(o_pend), 32'h9);
    chk("prio_id0",  32'(o_evt_id), 32'h0);
    chk("prio_irq",  32'(o_irq), 32'h1);
    i_mask = 4'b1000;
    #1;
    chk("prio_id3",  32'(o_evt_id), 32'h3);
    chk("prio_val3", 32'(o_evt_valid), 32'h1);
    i_mask = 4'b0000;
    #1;
    chk("mask0_irq",   32'(o_irq), 32'h0);
    chk("mask0_valid", 32'(o_evt_valid), 32'h0);
    chk("mask0_id",    32'(o_evt_id), 32'h0);
    chk("mask0_pend",  32'(o_pend), 32'h9);
    chk("prio_missed", 32'(o_missed), 32'h0001);
    i_ack = 4'b1001;
    tick();
    i_ack = '0;
    chk("prio_acked", 32'(o_pend), 32'h0);

    // Level mode on ch2: ack ignored while high.
    i_mode = 4'b0100;
    i_mask = 4'b0100;
    i_evt  = 4'b0100;
    tick();
    tick();
    tick();
    chk("lvl_pend", 32'(o_pend), 32'h4);
    i_ack = 4'b0100;
    tick();
    i_ack = '0;
    tick();
    tick();
    chk("lvl_hold",   32'(o_pend), 32'h4);
    chk("lvl_missed", 32'(o_missed), 32'h0001);
    chk("lvl_id",     32'(o_evt_id), 32'h2);
    i_evt = '0;
    tick();
    tick();
    i_mode = 4'b0000;
    tick();
    chk("mode_chg_keep", 32'(o_pend), 32'h4);
    i_ack = 4'b0100;
    tick();
    i_ack = '0;
    chk("lvl_acked", 32'(o_pend), 32'h0);

    // Async reset while ch1 pending with three missed events.
    i_mask = 4'b0010;
    pulse_evt(4'b0010);
    pulse_evt(4'b0010);
    pulse_evt(4'b0010);
    pulse_evt(4'b0010);
    chk("pre_rst_pend",   32'(o_pend), 32'h2);
    chk("pre_rst_missed", 32'(o_missed), 32'h0031);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pend",   32'(o_pend), 32'h0);
    chk("arst_irq",    32'(o_irq), 32'h0);
    chk("arst_id",     32'(o_evt_id), 32'h0);
    chk("arst_valid",  32'(o_evt_valid), 32'h0);
    chk("arst_missed", 32'(o_missed), 32'h0);

    // Event held high across reset release is captured as an edge.
    i_evt = 4'b0010;
    tick();
    rstn = 1'b1;
    tick();
    tick();
    chk("rel_not_yet", 32'(o_pend), 32'h0);
    tick();
    chk("rel_pend", 32'(o_pend), 32'h2);
    chk("rel_irq",  32'(o_irq), 32'h1);
    i_evt = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rojo_evt_latch.md
ROJO_EVT_LATCH -- requirements
Module: rojo_evt_latch

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of event channels (1..16).
REQ-002 SHALL provide parameter CNT_W, default 4, width of each per-channel missed-event counter (2..8).
REQ-003 SHALL provide parameter SYNC, default 1, adding a 2-flop input synchroniser on i_evt when 1 and none when 0.
REQ-004 clk  input  1  sole clock; every flop is on the rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 i_evt  input  NCH  raw event sources, e.g. bot update strobe.
REQ-007 i_mode  input  NCH  per channel: 0 = rising-edge event, 1 = level event.
REQ-008 i_mask  input  NCH  per channel: 1 = channel enabled for interrupt.
REQ-009 i_ack  input  NCH  per channel: one-cycle pending-clear strobe from CPU.
REQ-010 i_clr_missed  input  NCH  per channel: one-cycle missed-counter clear strobe.
REQ-011 o_pend  output  NCH  registered sticky pending flags.
REQ-012 o_irq  output  1  combined interrupt request.
REQ-013 o_evt_id  output  max(1,clog2(NCH))  lowest-index channel that is pending and enabled.
REQ-014 o_evt_valid  output  1  o_evt_id is meaningful.
REQ-015 o_missed  output  NCH*CNT_W  packed missed counters; channel k occupies bits [k*CNT_W +: CNT_W].

Function
REQ-016 Sampled event evt_s SHALL be i_evt after 2 flops when SYNC=1, i_evt directly when SYNC=0.
REQ-017 Each channel SHALL register prev = evt_s every cycle; the detect term is evt_s & ~prev when i_mode=0, and evt_s when i_mode=1.
REQ-018 Each channel SHALL act as a two-state FSM: IDLE (o_pend=0) and PEND (o_pend=1).
REQ-019 IDLE->PEND SHALL occur on the clock edge where detect=1; latency from i_evt rising to o_pend is 1 cycle (SYNC=0) or 3 cycles (SYNC=1).
REQ-020 PEND->IDLE SHALL occur on the clock edge where i_ack=1 and detect=0.
REQ-021 When i_ack=1 and detect=1 in the same cycle, o_pend SHALL remain 1: the new event is kept and the missed counter is not incremented.
REQ-022 i_ack in IDLE SHALL have no effect.
REQ-023 In edge mode, a detect while in PEND with i_ack=0 SHALL increment that channel's missed counter.
REQ-024 In level mode the missed counter SHALL NOT increment; o_pend stays 1 while the level is high, regardless of i_ack.
REQ-025 Missed counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 i_clr_missed SHALL zero the counter; if an increment occurs in the same cycle, the counter SHALL become 1.
REQ-027 Pending capture SHALL be independent of i_mask; the mask only gates o_irq, o_evt_id and o_evt_valid.
REQ-028 o_irq SHALL equal the OR of (o_pend & i_mask), combinational from registered state, with no added latency.
REQ-029 o_evt_id SHALL be the lowest set index of (o_pend & i_mask), else 0.
REQ-030 o_evt_valid SHALL equal o_irq.
REQ-031 A change of i_mode SHALL take effect on the next detect evaluation; existing pending state SHALL be preserved.

Reset
REQ-032 While rstn=0, the block SHALL asynchronously clear synchroniser flops, prev, o_pend and all counters to 0; o_irq=0, o_evt_id=0, o_evt_valid=0.
REQ-033 On reset release with evt_s already high, the block SHALL treat it as a rising edge on the first clock.
REQ-034 Assertion of rstn=0 mid-operation SHALL discard all pending events and counts without waiting for a clock.

Verification
REQ-035 NCH=4, SYNC=1, ch1 edge-mode, mask=4'b0010: pulse i_evt[1] one cycle -> o_pend[1]=1 three cycles later, o_irq=1, o_evt_id=1; i_ack[1] -> o_pend[1]=0 and o_irq=0 the next cycle.
REQ-036 ch0 pending with no ack, 20 further edge events -> o_missed[3:0]=4'hF (saturated); i_clr_missed[0] -> 0.
REQ-037 i_ack[2] coincident with a new edge detect on ch2 -> o_pend[2] stays 1 and o_missed for ch2 is unchanged.
REQ-038 ch0 and ch3 pending, mask=4'b1001 -> o_evt_id=0; mask=4'b1000 -> o_evt_id=3; mask=0 -> o_irq=0 while o_pend stays 4'b1001.
REQ-039 ch2 level-mode held high with i_ack[2] pulsed -> o_pend[2] stays 1 and missed=0; level low then i_ack[2] -> o_pend[2]=0.
REQ-040 rstn pulsed low between clock edges while ch1 is pending with missed=3 -> all outputs 0 immediately.
